// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared definitions for the WS2812B serializer slice.
//   - ws_state_e   : serializer line states (idle, high phase, low phase, strip latch)
//   - WS_*         : default pixel width and NRZ timing constants at a 20 MHz clock
//   - ws_max       : helper used to size the shared phase counter
package ws2812b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } ws_state_e;

    localparam int unsigned WS_DATA_WIDTH   = 24;
    localparam int unsigned WS_T0H_CYCLES   = 8;     // 400 ns
    localparam int unsigned WS_T1H_CYCLES   = 16;    // 800 ns
    localparam int unsigned WS_BIT_CYCLES   = 25;    // 1.25 us
    localparam int unsigned WS_RESET_CYCLES = 6000;  // 300 us

    function automatic int unsigned ws_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812b_bit_timer.sv
// ws2812b_bit_timer: loadable down-counter timing one line phase.
//   clk_i      : clock (rising edge)
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i this cycle (takes priority over counting)
//   load_val_i : phase length minus one
//   expired_o  : count has reached zero (last cycle of the loaded phase)
module ws2812b_bit_timer #(
    parameter int unsigned CNT_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/ws2812b_serializer.sv
// ws2812b_serializer: valid/ready pixel sink driving a WS2812B strip with NRZ timing.
// A one-word holding register lets the next pixel be accepted while the current
// one shifts out MSB first; a word tagged with latch is followed by the strip
// reset low period.
//   clk20    : 20 MHz clock (rising edge)
//   reset    : synchronous active-high reset
//   data_in  : pixel word, captured on valid && ready
//   valid    : data_in/latch offered
//   latch    : data_in is the last pixel of the frame
//   ready    : holding register empty (registered)
//   led      : serial line to the strip (registered)
//   underrun : sticky, only when WS2812B_SERIALIZER_UNDERRUN_EN is defined; set when
//              a non-latched word finishes with no successor held, cleared by reset
module ws2812b_serializer
    import ws2812b_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = WS_DATA_WIDTH,
    parameter int unsigned T0H_CYCLES   = WS_T0H_CYCLES,
    parameter int unsigned T1H_CYCLES   = WS_T1H_CYCLES,
    parameter int unsigned BIT_CYCLES   = WS_BIT_CYCLES,
    parameter int unsigned RESET_CYCLES = WS_RESET_CYCLES
) (
    input  logic                  clk20,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    input  logic                  latch,
    output logic                  ready,
    output logic                  led
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
    ,
    output logic                  underrun
`endif
);

    localparam int unsigned MAX_CYC = ws_max(ws_max(T0H_CYCLES, T1H_CYCLES),
                                             ws_max(BIT_CYCLES, RESET_CYCLES));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);
    localparam int unsigned IDX_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    ws_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_latch_q, hold_latch_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  shift_latch_q, shift_latch_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  ready_q, ready_d;
    logic                  led_q, led_d;

    logic                  accept;
    logic                  load_word;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_expired;
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
    logic                  underrun_q;
    logic                  underrun_set;
`endif

    // Phase lengths are loaded as N-1 so the timer expires on the Nth cycle.
    function automatic logic [CNT_W-1:0] high_cnt(input logic b);
        return b ? CNT_W'(T1H_CYCLES - 1) : CNT_W'(T0H_CYCLES - 1);
    endfunction

    function automatic logic [CNT_W-1:0] low_cnt(input logic b);
        return b ? CNT_W'(BIT_CYCLES - T1H_CYCLES - 1) : CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
    endfunction

    assign accept  = valid && ready_q;
    assign shifted = shift_q << 1;

    ws2812b_bit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clk20),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_latch_d  = hold_latch_q;
        hold_full_d   = hold_full_q;
        shift_d       = shift_q;
        shift_latch_d = shift_latch_q;
        bit_idx_d     = bit_idx_q;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        load_word     = 1'b0;
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
        underrun_set  = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) load_word = 1'b1;
            end
            ST_HIGH: begin
                if (tmr_expired) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = low_cnt(shift_q[DATA_WIDTH-1]);
                end
            end
            ST_LOW: begin
                if (tmr_expired) begin
                    if (bit_idx_q != '0) begin
                        shift_d   = shifted;
                        bit_idx_d = bit_idx_q - 1'b1;
                        state_d   = ST_HIGH;
                        tmr_load  = 1'b1;
                        tmr_val   = high_cnt(shifted[DATA_WIDTH-1]);
                    end else if (shift_latch_q) begin
                        state_d  = ST_LATCH;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(RESET_CYCLES - 1);
                    end else if (hold_full_q) begin
                        // Chain straight into the next word so bit periods stay uniform.
                        load_word = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
                        underrun_set = 1'b1;
`endif
                    end
                end
            end
            ST_LATCH: begin
                if (tmr_expired) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_word) begin
            shift_d       = hold_q;
            shift_latch_d = hold_latch_q;
            hold_full_d   = 1'b0;
            bit_idx_d     = IDX_W'(DATA_WIDTH - 1);
            state_d       = ST_HIGH;
            tmr_load      = 1'b1;
            tmr_val       = high_cnt(hold_q[DATA_WIDTH-1]);
        end

        // Acceptance needs an empty holder, a transfer needs a full one: never both.
        if (accept) begin
            hold_d       = data_in;
            hold_latch_d = latch;
            hold_full_d  = 1'b1;
        end

        ready_d = !hold_full_d;
        led_d   = (state_d == ST_HIGH);
    end

    always_ff @(posedge clk20) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            hold_latch_q  <= 1'b0;
            hold_full_q   <= 1'b0;
            shift_q       <= '0;
            shift_latch_q <= 1'b0;
            bit_idx_q     <= '0;
            ready_q       <= 1'b0;
            led_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_latch_q  <= hold_latch_d;
            hold_full_q   <= hold_full_d;
            shift_q       <= shift_d;
            shift_latch_q <= shift_latch_d;
            bit_idx_q     <= bit_idx_d;
            ready_q       <= ready_d;
            led_q         <= led_d;
        end
    end

`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
    always_ff @(posedge clk20) begin
        if (reset) begin
            underrun_q <= 1'b0;
        end else if (underrun_set) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`endif

    assign ready = ready_q;
    assign led   = led_q;

endmodule

// File: tb/tb_ws2812b_serializer.sv
// tb_ws2812b_serializer: randomized and directed checks of ws2812b_serializer.
// The reference derives the expected pulse train from the pixel words alone:
// each bit is one pulse of T1H or T0H high, consecutive rises are BIT apart, and
// after a latched word the next rise comes BIT + RESET + 1 cycles later (strip
// reset period plus the single idle cycle that moves the held word out).
// Honours WS2812B_SERIALIZER_UNDERRUN_EN when defined.
module tb_ws2812b_serializer;

    localparam int DW   = 24;
    localparam int T0H  = 8;
    localparam int T1H  = 16;
    localparam int BITC = 25;
    localparam int RSTC = 6000;

    logic          clk20   = 1'b0;
    logic          reset   = 1'b1;
    logic          valid   = 1'b0;
    logic          latch   = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready;
    logic          led;
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
    logic          underrun;
`endif

    ws2812b_serializer #(
        .DATA_WIDTH   (DW),
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .BIT_CYCLES   (BITC),
        .RESET_CYCLES (RSTC)
    ) dut (
        .clk20    (clk20),
        .reset    (reset),
        .data_in  (data_in),
        .valid    (valid),
        .latch    (latch),
        .ready    (ready),
        .led      (led)
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
        ,
        .underrun (underrun)
`endif
    );

    always #5 clk20 = ~clk20;

    int total = 0;
    int bad   = 0;

    // Line monitor: cycle numbers of every rise and fall, sampled mid-cycle.
    int   ncyc = 0;
    int   rises[$];
    int   falls[$];
    logic led_prev = 1'b0;

    always @(negedge clk20) begin
        ncyc++;
        if (led === 1'b1 && led_prev === 1'b0) rises.push_back(ncyc);
        if (led === 1'b0 && led_prev === 1'b1) falls.push_back(ncyc);
        led_prev = led;
    end

    logic [DW-1:0] sent_w[$];
    bit            sent_l[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rises.delete();
        falls.delete();
        sent_w.delete();
        sent_l.delete();
    endtask

    // Offer one word as soon as ready is seen; returns on the negedge after acceptance.
    task automatic send(input logic [DW-1:0] w, input logic l);
        int k = 0;
        while (ready !== 1'b1 && k < 20000) begin
            @(negedge clk20);
            k++;
        end
        if (k >= 20000) check("send_ready_timeout", {31'd0, ready}, 32'd1);
        data_in = w;
        latch   = l;
        valid   = 1'b1;
        @(negedge clk20);
        valid   = 1'b0;
        latch   = 1'b0;
        data_in = $urandom;
        sent_w.push_back(w);
        sent_l.push_back(l);
    endtask

    task automatic wait_pulses(input int n);
        int k = 0;
        while (falls.size() < n && k < 30000) begin
            @(negedge clk20);
            k++;
        end
        check("pulses_seen", falls.size(), n);
        repeat (40) @(negedge clk20);
    endtask

    // Compare the captured pulse train against the words sent since the last clear.
    task automatic check_stream(input string name);
        int n;
        int m;
        logic [DW-1:0] w;
        int exp_h;
        int exp_p;
        n = 24 * sent_w.size();
        check($sformatf("%s_rises", name), rises.size(), n);
        check($sformatf("%s_falls", name), falls.size(), n);
        m = (rises.size() < falls.size()) ? rises.size() : falls.size();
        if (m > n) m = n;
        for (int i = 0; i < m; i++) begin
            w = sent_w[i / DW];
            exp_h = w[DW - 1 - (i % DW)] ? T1H : T0H;
            check($sformatf("%s_high[%0d]", name, i), falls[i] - rises[i], exp_h);
            if (i > 0) begin
                exp_p = (i % DW == 0 && sent_l[i / DW - 1]) ? BITC + RSTC + 1 : BITC;
                check($sformatf("%s_period[%0d]", name, i), rises[i] - rises[i-1], exp_p);
            end
        end
        clear_mon();
    endtask

    initial begin
        int n;
        int k;

        // Reset and idle line.
        reset = 1'b1;
        repeat (3) @(negedge clk20);
        check("rst_led", {31'd0, led}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk20);
        check("ready_after_rst", {31'd0, ready}, 32'd1);
        check("led_after_rst", {31'd0, led}, 32'd0);
        clear_mon();
        repeat (100) @(negedge clk20);
        check("idle_no_edges", rises.size(), 0);
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
        check("underrun_rst", {31'd0, underrun}, 32'd0);
`endif

        // Random stream, only the last word latched.
        n = $urandom_range(3, 6);
        for (int i = 0; i < n; i++) send($urandom, (i == n - 1));
        wait_pulses(24 * n);
        check_stream("rand");
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
        check("underrun_latched_only", {31'd0, underrun}, 32'd0);
`endif

        // Single unlatched word 0xFF0000.
        send(24'hFF0000, 1'b0);
        wait_pulses(24);
        check("span_first_to_last_rise", rises[23] - rises[0], 23 * BITC);
        check_stream("ff0000");
        check("led_low_after", {31'd0, led}, 32'd0);
        check("ready_after_word", {31'd0, ready}, 32'd1);
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
        check("underrun_set", {31'd0, underrun}, 32'd1);
`endif

        // Back-to-back words.
        send(24'h00FF00, 1'b0);
        send(24'h0000FF, 1'b0);
        wait_pulses(48);
        check_stream("b2b");

        // Latched word followed by a held word waiting out the latch period.
        send(24'h123456, 1'b1);
        send(24'hFFFFFF, 1'b0);
        k = 0;
        while (falls.size() < 24 && k < 2000) begin
            @(negedge clk20);
            k++;
        end
        repeat (1000) @(negedge clk20);
        check("latch_ready_held", {31'd0, ready}, 32'd0);
        check("latch_led_low", {31'd0, led}, 32'd0);
        check("latch_no_early_rise", rises.size(), 24);
        wait_pulses(48);
        check_stream("latch");
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
        check("underrun_sticky", {31'd0, underrun}, 32'd1);
`endif

        // Reset in the middle of a long high pulse with a word held.
        send(24'hFFFFFF, 1'b0);
        send(24'hAAAAAA, 1'b0);
        k = 0;
        while (rises.size() < 1 && k < 100) begin
            @(negedge clk20);
            k++;
        end
        repeat (5) @(negedge clk20);
        check("mid_pulse_led_high", {31'd0, led}, 32'd1);
        reset = 1'b1;
        @(negedge clk20);
        check("mid_rst_led", {31'd0, led}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk20);
        check("mid_rst_ready_after", {31'd0, ready}, 32'd1);
`ifdef WS2812B_SERIALIZER_UNDERRUN_EN
        check("underrun_cleared", {31'd0, underrun}, 32'd0);
`endif
        clear_mon();
        repeat (100) @(negedge clk20);
        check("held_word_discarded", rises.size(), 0);
        send($urandom, 1'b0);
        wait_pulses(24);
        check_stream("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
